ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit sitting directly upstream of the instruction ROM/memory port. It generates sequential word addresses from a fetch PC, drives the memory request/response handshake with multiple requests in flight, buffers returned instructions with their PCs in a small FIFO, and presents them to decode with a valid/ready handshake. Branch/jump redirects flush the FIFO and discard in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 4, instruction buffer entries (power of two, ≥2)
- MAX_OUT, 2, maximum outstanding memory requests (1..FIFO_DEPTH)

- clk  in  1  single clock, all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- request_o  out  1  memory request, sampled by memory at posedge
- instAddr_o  out  32  request address (word aligned), valid with request_o
- inst_i  in  32  returned instruction word
- dataOk_i  in  1  response strobe; one per request, in request order, latency ≥1 cycle
- jumpFlag_i  in  1  redirect request from execute
- jumpAddr_i  in  32  redirect target; bits [1:0] forced to 0
- instValid_o  out  1  FIFO head valid
- inst_o  out  32  FIFO head instruction
- pc_o  out  32  FIFO head PC
- decodeReady_i  in  1  decode accepts head this cycle

## Operation
- Registers: fetchPc (next address to request), pushPc (PC of next accepted response), outCnt (in-flight requests), FIFO (count, rd/wr pointers), state.
- FSM states IDLE, FETCH, FLUSH:
  - IDLE: entered on reset; unconditionally -> FETCH next cycle. No requests.
  - FETCH: issue when outCnt < MAX_OUT and outCnt + count < FIFO_DEPTH (space reserved for every in-flight word).
  - FLUSH: no issue; every arriving response is dropped; -> FETCH when outCnt reaches 0 (count including the response arriving this cycle).
- request_o, instAddr_o are functions of registered state only (no combinational path from jumpFlag_i, dataOk_i or decodeReady_i). instAddr_o = fetchPc.
- Issue (request_o=1): fetchPc += 4 (32-bit wrap), outCnt += 1.
- Response (dataOk_i=1): outCnt -= 1; in FETCH and no redirect this cycle, push {pushPc, inst_i}, pushPc += 4. dataOk_i with outCnt=0 is ignored.
- Pop: instValid_o && decodeReady_i; issue, push and pop in the same cycle all take effect.
- Redirect (jumpFlag_i=1 at the edge, any state except IDLE): FIFO emptied (same-cycle pop and push discarded); fetchPc and pushPc <= {jumpAddr_i[31:2],2'b00}; any response this cycle is dropped; request issued this cycle counts as in flight; state -> FLUSH if resulting outCnt > 0, else FETCH. Redirect in FLUSH restarts targets, stays in FLUSH. jumpFlag_i in IDLE ignored.

## Timing
- Reset values: request_o 0, instAddr_o RESET_PC, instValid_o 0, inst_o 0, pc_o 0; fetchPc = pushPc = RESET_PC, outCnt 0, FIFO empty, state IDLE.
- First request_o=1 in the second cycle after reset deassertion (IDLE lasts one cycle).
- With 1-cycle memory and decodeReady_i held high: one request per cycle, instValid_o first high 1 cycle after first dataOk_i, then one instruction per cycle.
- inst_o/pc_o driven from FIFO storage; valid in the cycle after the push.
- Redirect to first new request: next cycle if no requests in flight, otherwise the cycle after the last discarded response.
- FIFO full: issue stalls, no overflow ever possible given the reservation rule.
- Reset mid-operation: immediate return to reset values; later dataOk_i from pre-reset requests ignored by outCnt=0 rule.

## Test plan
- Reset/boot: RESET_PC=0x100, 1-cycle ROM, ready=1 -> requests 0x100,0x104,0x108…; pc_o/inst_o match ROM words in order, instValid_o continuous after 3 cycles.
- Backpressure: decodeReady_i=0 for 10 cycles -> exactly FIFO_DEPTH=4 entries buffered, request_o low, no lost/duplicated words after ready returns.
- Redirect with one in flight: jumpFlag_i, jumpAddr_i=0x203 while outCnt=1 -> in-flight word dropped, FIFO empty, next request at 0x200, first pc_o=0x200.
- Redirect coinciding with dataOk_i and pop: responding word not pushed, head not delivered twice, pc_o continues from target.
- Variable latency ROM (2–3 cycles, MAX_OUT=2): outCnt never exceeds 2, PC/instruction pairing correct across 50 words and a back-to-back double redirect.
- Async reset asserted mid-stream: outputs at reset values immediately; stray dataOk_i after reset ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues sequential word fetches with several requests in flight,
// buffers returned words with their PCs, and hands them to decode; redirects flush everything.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MAX_OUT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        request_o,
    output logic [31:0] instAddr_o,
    input  logic [31:0] inst_i,
    input  logic        dataOk_i,
    input  logic        jumpFlag_i,
    input  logic [31:0] jumpAddr_i,
    output logic        instValid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    input  logic        decodeReady_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [31:0]        fetch_pc_reg, fetch_pc_next;
    logic [31:0]        push_pc_reg, push_pc_next;
    logic [CNT_W-1:0]   out_cnt_reg, out_cnt_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [31:0]        inst_mem_reg [FIFO_DEPTH];
    logic [31:0]        pc_mem_reg   [FIFO_DEPTH];

    logic        redirect;
    logic        resp;
    logic        push;
    logic        pop;
    logic [31:0] target;
    logic [CNT_W:0] reserved;

    // Every in-flight word already owns a FIFO slot, so the buffer can never overflow.
    assign reserved    = {1'b0, out_cnt_reg} + {1'b0, count_reg};
    assign request_o   = (state_reg == FETCH) && (out_cnt_reg < MAX_OUT_C) && (reserved < DEPTH_C);
    assign instAddr_o  = fetch_pc_reg;

    assign target      = jumpAddr_i & ~32'h3;
    assign redirect    = jumpFlag_i && (state_reg != IDLE);
    assign resp        = dataOk_i && (out_cnt_reg != '0);
    assign push        = resp && (state_reg == FETCH) && !redirect;
    assign pop         = instValid_o && decodeReady_i && !redirect;

    assign instValid_o = (count_reg != '0);
    assign inst_o      = inst_mem_reg[rd_ptr_reg];
    assign pc_o        = pc_mem_reg[rd_ptr_reg];

    always_comb begin
        state_next    = state_reg;
        out_cnt_next  = out_cnt_reg + CNT_W'(request_o) - CNT_W'(resp);
        fetch_pc_next = request_o ? fetch_pc_reg + 32'd4 : fetch_pc_reg;
        push_pc_next  = push ? push_pc_reg + 32'd4 : push_pc_reg;
        count_next    = count_reg + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_next   = rd_ptr_reg + PTR_W'(pop);
        wr_ptr_next   = wr_ptr_reg + PTR_W'(push);

        if (redirect) begin
            fetch_pc_next = target;
            push_pc_next  = target;
            count_next    = '0;
            rd_ptr_next   = wr_ptr_reg;
        end

        case (state_reg)
            IDLE:  state_next = FETCH;
            FETCH,
            FLUSH: begin
                if (redirect || (state_reg == FLUSH)) begin
                    state_next = (out_cnt_next != '0) ? FLUSH : FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            push_pc_reg  <= RESET_PC;
            out_cnt_reg  <= '0;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            push_pc_reg  <= push_pc_next;
            out_cnt_reg  <= out_cnt_next;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
        end
    end

    // Head must be readable the cycle after a push, so the buffer is registers, not block RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                inst_mem_reg[i] <= '0;
                pc_mem_reg[i]   <= '0;
            end
        end else if (push) begin
            inst_mem_reg[wr_ptr_reg] <= inst_i;
            pc_mem_reg[wr_ptr_reg]   <= push_pc_reg;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: boot table, backpressure, redirects, variable-latency ROM and async reset.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        request_o;
    logic [31:0] instAddr_o;
    logic [31:0] inst_i;
    logic        dataOk_i;
    logic        jumpFlag_i;
    logic [31:0] jumpAddr_i;
    logic        instValid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        decodeReady_i;

    ifu_fetch #(
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(DEPTH),
        .MAX_OUT   (MAXO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .request_o    (request_o),
        .instAddr_o   (instAddr_o),
        .inst_i       (inst_i),
        .dataOk_i     (dataOk_i),
        .jumpFlag_i   (jumpFlag_i),
        .jumpAddr_i   (jumpAddr_i),
        .instValid_o  (instValid_o),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .decodeReady_i(decodeReady_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic        chk_head;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    vec_t        boot_vec [7];
    req_t        mq [$];
    int          checks;
    int          errors;
    int          cyc;
    int          lat_min;
    int          lat_max;
    int          last_due;
    int          delivered;
    logic [31:0] exp_pc;
    logic [31:0] flush_target;
    bit          flush_pending;
    bit          post_jump;
    bit          stray_pending;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hC3A5_5A00;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // In-order ROM: one response per cycle at most, latency drawn from [lat_min, lat_max].
    task automatic mem_model();
        int d;
        dataOk_i = 1'b0;
        inst_i   = 32'h0;
        if (stray_pending && mq.size() == 0) begin
            dataOk_i      = 1'b1;
            inst_i        = 32'hBAD0_BAD0;
            stray_pending = 1'b0;
        end else if (mq.size() != 0 && mq[0].due <= cyc) begin
            dataOk_i = 1'b1;
            inst_i   = rom(mq[0].addr);
            void'(mq.pop_front());
        end
        if (request_o) begin
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq.push_back('{instAddr_o, d});
        end
    endtask

    // Called at a negedge with this cycle's inputs set; returns at the next negedge.
    task automatic step();
        chk1("outstanding_bound", mq.size() <= MAXO, 1'b1);
        if (flush_pending) begin
            if (mq.size() != 0) begin
                chk1("flush_no_issue", request_o, 1'b0);
            end else begin
                chk1("redirect_first_req", request_o, 1'b1);
                chk("redirect_first_addr", instAddr_o, flush_target);
                flush_pending = 1'b0;
            end
        end
        if (post_jump) begin
            chk1("fifo_empty_after_redirect", instValid_o, 1'b0);
            post_jump = 1'b0;
        end
        mem_model();
        if (jumpFlag_i) begin
            exp_pc        = jumpAddr_i & ~32'h3;
            flush_target  = exp_pc;
            flush_pending = 1'b1;
            post_jump     = 1'b1;
        end else if (instValid_o && decodeReady_i) begin
            chk("pc_o", pc_o, exp_pc);
            chk("inst_o", inst_o, rom(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_vec(input int i);
        chk1($sformatf("boot%0d_req", i), request_o, boot_vec[i].req);
        chk($sformatf("boot%0d_addr", i), instAddr_o, boot_vec[i].addr);
        chk1($sformatf("boot%0d_valid", i), instValid_o, boot_vec[i].valid);
        if (boot_vec[i].chk_head) begin
            chk($sformatf("boot%0d_pc", i), pc_o, boot_vec[i].pc);
            chk($sformatf("boot%0d_inst", i), inst_o, boot_vec[i].inst);
        end
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 50; k++) begin
            if (instValid_o) break;
            step();
        end
        chk1(name, instValid_o, 1'b1);
    endtask

    // Entered with reset asserted; releases it and walks the boot table.
    task automatic run_boot(input bit stray);
        @(negedge clk);
        check_vec(0);
        mq.delete();
        last_due      = 0;
        exp_pc        = RST_PC;
        flush_pending = 1'b0;
        post_jump     = 1'b0;
        lat_min       = 1;
        lat_max       = 1;
        jumpFlag_i    = 1'b0;
        decodeReady_i = 1'b1;
        dataOk_i      = 1'b0;
        reset         = 1'b0;
        step();
        stray_pending = stray;
        for (int i = 1; i < 7; i++) begin
            check_vec(i);
            step();
        end
    endtask

    initial begin
        logic resp_now;
        checks = 0; errors = 0; cyc = 0; delivered = 0;
        inst_i = '0; dataOk_i = 1'b0; jumpFlag_i = 1'b0; jumpAddr_i = '0;
        decodeReady_i = 1'b1; stray_pending = 1'b0;
        lat_min = 1; lat_max = 1; last_due = 0; exp_pc = RST_PC;
        flush_pending = 1'b0; post_jump = 1'b0; flush_target = '0;

        //             req   addr          valid head  pc            inst
        boot_vec[0] = '{1'b0, 32'h0000_0100, 1'b0, 1'b1, 32'h0,        32'h0};
        boot_vec[1] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0,        32'h0};
        boot_vec[2] = '{1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0,        32'h0};
        boot_vec[3] = '{1'b1, 32'h0000_0108, 1'b1, 1'b1, 32'h0000_0100, rom(32'h0000_0100)};
        boot_vec[4] = '{1'b1, 32'h0000_010C, 1'b1, 1'b1, 32'h0000_0104, rom(32'h0000_0104)};
        boot_vec[5] = '{1'b1, 32'h0000_0110, 1'b1, 1'b1, 32'h0000_0108, rom(32'h0000_0108)};
        boot_vec[6] = '{1'b1, 32'h0000_0114, 1'b1, 1'b1, 32'h0000_010C, rom(32'h0000_010C)};

        repeat (2) @(negedge clk);
        run_boot(1'b0);
        repeat (10) step();

        // Backpressure: buffer fills to exactly DEPTH and fetching stops.
        decodeReady_i = 1'b0;
        repeat (10) step();
        chk1("bp_req_low", request_o, 1'b0);
        chk1("bp_valid", instValid_o, 1'b1);
        chk("bp_fetch_addr", instAddr_o, exp_pc + 32'd16);
        chk("bp_none_in_flight", 32'(mq.size()), 32'd0);
        decodeReady_i = 1'b1;
        repeat (8) step();

        // Redirect with one request in flight.
        lat_min = 2; lat_max = 2;
        repeat (6) step();
        for (int k = 0; k < 20; k++) begin
            if (mq.size() == 1) break;
            step();
        end
        chk("one_in_flight", 32'(mq.size()), 32'd1);
        jumpFlag_i = 1'b1; jumpAddr_i = 32'h0000_0203;
        step();
        jumpFlag_i = 1'b0;
        wait_valid("redirect_valid");
        chk("redirect_first_pc", pc_o, 32'h0000_0200);
        repeat (10) step();

        // Redirect coinciding with a response and a pop.
        lat_min = 1; lat_max = 1;
        repeat (5) step();
        resp_now = (mq.size() != 0) ? (mq[0].due <= cyc) : 1'b0;
        chk1("coincide_resp", resp_now, 1'b1);
        chk1("coincide_pop", instValid_o, 1'b1);
        jumpFlag_i = 1'b1; jumpAddr_i = 32'h0000_0300;
        step();
        jumpFlag_i = 1'b0;
        wait_valid("coincide_valid");
        chk("coincide_first_pc", pc_o, 32'h0000_0300);
        repeat (10) step();

        // Variable-latency ROM with random decode stalls.
        lat_min = 2; lat_max = 3; delivered = 0;
        for (int i = 0; i < 600 && delivered < 50; i++) begin
            decodeReady_i = ($urandom_range(3, 0) != 0);
            step();
        end
        chk1("varlat_50_words", delivered >= 50, 1'b1);

        // Back-to-back double redirect.
        decodeReady_i = 1'b1;
        jumpFlag_i = 1'b1; jumpAddr_i = 32'h0000_0400;
        step();
        jumpAddr_i = 32'h0000_0501;
        step();
        jumpFlag_i = 1'b0;
        wait_valid("double_redirect_valid");
        chk("double_redirect_pc", pc_o, 32'h0000_0500);
        delivered = 0;
        for (int i = 0; i < 600 && delivered < 50; i++) begin
            decodeReady_i = ($urandom_range(3, 0) != 0);
            step();
        end
        chk1("varlat2_50_words", delivered >= 50, 1'b1);

        // Asynchronous reset in the middle of a stream.
        lat_min = 1; lat_max = 1; decodeReady_i = 1'b1;
        repeat (5) step();
        #2 reset = 1'b1;
        #1;
        chk1("async_rst_req", request_o, 1'b0);
        chk("async_rst_addr", instAddr_o, RST_PC);
        chk1("async_rst_valid", instValid_o, 1'b0);
        chk("async_rst_inst", inst_o, 32'h0);
        chk("async_rst_pc", pc_o, 32'h0);
        run_boot(1'b1);
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
